// File: rtl/mult_div_unit_if.sv
// Operand/result bundle between the register-file stage and the multiply/divide unit.
interface mult_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (output start, output op, output a, output b,
                    input busy, input done, input hi, input lo);
    modport slave  (input start, input op, input a, input b,
                    output busy, output done, output hi, output lo);
endinterface

// File: rtl/mult_div_unit.sv
// Iterative MIPS multiply/divide unit owning the architectural HI/LO registers.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   S_IDLE  | waiting for a request; MTHI/MTLO are serviced here in one edge
//   S_CALC  | one shift-add (mult) or restoring shift-subtract (div) per edge
//   S_FIXUP | sign correction / divide-by-zero substitution, HI/LO written
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input logic            clk,
    input logic            rst_n,
    mult_div_unit_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIXUP} state_t;

    state_t               state_q;
    logic [CW-1:0]        cnt_q;
    // mult: {partial product, remaining multiplier}; div: {remainder, dividend/quotient}
    logic [2*WIDTH-1:0]   acc_q;
    logic [2*WIDTH-1:0]   acc_d;
    logic [WIDTH-1:0]     opnd_q;      // |multiplicand| or |divisor|
    logic [WIDTH-1:0]     a_raw_q;     // original dividend, returned in HI on divide by zero
    logic [WIDTH-1:0]     hi_q;
    logic [WIDTH-1:0]     lo_q;
    logic                 is_div_q;
    logic                 neg_lo_q;    // product or quotient must be negated
    logic                 neg_hi_q;    // remainder must be negated
    logic                 div0_q;
    logic                 busy_q;
    logic                 done_q;

    logic                 sign_a;
    logic                 sign_b;
    logic [WIDTH-1:0]     abs_a;
    logic [WIDTH-1:0]     abs_b;
    logic [WIDTH-1:0]     addend;
    logic [WIDTH:0]       sum_d;
    logic [WIDTH:0]       rem_ext_d;
    logic [WIDTH:0]       diff_d;
    logic [2*WIDTH-1:0]   fix_prod;
    logic [WIDTH-1:0]     fix_q;
    logic [WIDTH-1:0]     fix_r;

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

    // Operand magnitudes; op[0] set means the unsigned variant.
    always_comb begin
        sign_a = bus.a[WIDTH-1] & ~bus.op[0];
        sign_b = bus.b[WIDTH-1] & ~bus.op[0];
        abs_a  = sign_a ? (~bus.a + 1'b1) : bus.a;
        abs_b  = sign_b ? (~bus.b + 1'b1) : bus.b;
    end

    // One iteration step and the final sign-corrected results.
    always_comb begin
        addend    = acc_q[0] ? opnd_q : '0;
        sum_d     = '0;
        rem_ext_d = acc_q[2*WIDTH-1:WIDTH-1];
        diff_d    = rem_ext_d - {1'b0, opnd_q};
        acc_d     = acc_q;
        if (!is_div_q) begin
            sum_d = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};
            acc_d = {sum_d, acc_q[WIDTH-1:1]};
        end else if (!diff_d[WIDTH]) begin
            acc_d = {diff_d[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end else begin
            acc_d = {rem_ext_d[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end
        fix_prod = neg_lo_q ? (~acc_q + 1'b1) : acc_q;
        fix_q    = neg_lo_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
        fix_r    = neg_hi_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1) : acc_q[2*WIDTH-1:WIDTH];
    end

    // Sequencer: accept in IDLE, iterate WIDTH edges, then fix up and publish.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            a_raw_q  <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            is_div_q <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            div0_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        case (bus.op)
                            OP_MULT, OP_MULTU: begin
                                acc_q    <= {{WIDTH{1'b0}}, abs_b};
                                opnd_q   <= abs_a;
                                is_div_q <= 1'b0;
                                neg_lo_q <= sign_a ^ sign_b;
                                neg_hi_q <= 1'b0;
                                div0_q   <= 1'b0;
                                a_raw_q  <= bus.a;
                                cnt_q    <= '0;
                                busy_q   <= 1'b1;
                                state_q  <= S_CALC;
                            end
                            OP_DIV, OP_DIVU: begin
                                acc_q    <= {{WIDTH{1'b0}}, abs_a};
                                opnd_q   <= abs_b;
                                is_div_q <= 1'b1;
                                neg_lo_q <= sign_a ^ sign_b;
                                neg_hi_q <= sign_a;
                                div0_q   <= (bus.b == '0);
                                a_raw_q  <= bus.a;
                                cnt_q    <= '0;
                                busy_q   <= 1'b1;
                                state_q  <= S_CALC;
                            end
                            OP_MTHI: hi_q <= bus.a;
                            OP_MTLO: lo_q <= bus.a;
                            default: ;
                        endcase
                    end
                end
                S_CALC: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_q <= S_FIXUP;
                    end
                end
                S_FIXUP: begin
                    if (!is_div_q) begin
                        {hi_q, lo_q} <= fix_prod;
                    end else if (div0_q) begin
                        hi_q <= a_raw_q;
                        lo_q <= '1;
                    end else begin
                        hi_q <= fix_r;
                        lo_q <= fix_q;
                    end
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: latency, signed/unsigned results, corner cases, reset abort.
module tb_mult_div_unit;
    localparam int W = 32;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    mult_div_unit_if #(.WIDTH(W)) bus ();

    mult_div_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge. Issues the op, scrambles a/b after acceptance, and returns
    // at the negedge where done is first seen (or when the cycle budget runs out).
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo);
        int e;
        int busy_n;
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = $urandom;
        bus.b     = $urandom;
        e      = 0;
        busy_n = 0;
        while (!bus.done && e < 100) begin
            if (bus.busy) busy_n++;
            @(negedge clk);
            e++;
        end
        check({tag, "_latency"}, e, W + 1);
        check({tag, "_busycyc"}, busy_n, W + 1);
        check({tag, "_hi"}, bus.hi, exp_hi);
        check({tag, "_lo"}, bus.lo, exp_lo);
        check({tag, "_busy_end"}, {31'b0, bus.busy}, 32'd0);
    endtask

    initial begin
        int e;
        checks   = 0;
        failures = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.op    = 3'b000;
        bus.a     = '0;
        bus.b     = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", {31'b0, bus.busy}, 32'd0);
        check("rst_done", {31'b0, bus.done}, 32'd0);
        check("rst_hi", bus.hi, 32'd0);
        check("rst_lo", bus.lo, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("multu_max", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        @(negedge clk);
        check("done_pulse", {31'b0, bus.done}, 32'd0);

        run_op("mult_m3x7", 3'b000, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        // next request issued in the done cycle
        run_op("mult_7xm3", 3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run_op("div_m7_2", 3'b010, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu_7_2", 3'b011, 32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003);
        run_op("div_7_m2", 3'b010, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
        run_op("div_ovf", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
        run_op("divu_by0", 3'b011, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 32'hFFFF_FFFF);
        run_op("div_m5_by0", 3'b010, 32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, 32'hFFFF_FFFF);
        run_op("multu_big", 3'b001, 32'h8000_0001, 32'h0000_0003, 32'h0000_0001, 32'h8000_0003);

        // undefined op is a no-op
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 3'b110;
        bus.a     = 32'h5555_5555;
        @(negedge clk);
        bus.start = 1'b0;
        check("nop_busy", {31'b0, bus.busy}, 32'd0);
        check("nop_hi", bus.hi, 32'h0000_0001);
        check("nop_lo", bus.lo, 32'h8000_0003);

        // requests while busy are dropped; running DIV 100/7 unaffected
        bus.start = 1'b1;
        bus.op    = 3'b010;
        bus.a     = 32'd100;
        bus.b     = 32'd7;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 3'b000;
        bus.a     = 32'd5;
        bus.b     = 32'd5;
        @(negedge clk);
        bus.op    = 3'b100;
        bus.a     = 32'hDEAD_BEEF;
        @(negedge clk);
        bus.start = 1'b0;
        check("busy_hold_hi", bus.hi, 32'h0000_0001);
        e = 0;
        while (!bus.done && e < 100) begin
            @(negedge clk);
            e++;
        end
        check("ign_done_seen", {31'b0, bus.done}, 32'd1);
        check("ign_hi", bus.hi, 32'd2);
        check("ign_lo", bus.lo, 32'd14);
        @(negedge clk);
        check("ign_no_restart", {31'b0, bus.busy}, 32'd0);

        // MTLO / MTHI in IDLE
        bus.start = 1'b1;
        bus.op    = 3'b101;
        bus.a     = 32'h0000_1234;
        @(negedge clk);
        bus.start = 1'b0;
        check("mtlo_lo", bus.lo, 32'h0000_1234);
        check("mtlo_hi", bus.hi, 32'd2);
        check("mtlo_done", {31'b0, bus.done}, 32'd0);
        check("mtlo_busy", {31'b0, bus.busy}, 32'd0);
        bus.start = 1'b1;
        bus.op    = 3'b100;
        bus.a     = 32'hCAFE_0001;
        @(negedge clk);
        bus.start = 1'b0;
        check("mthi_hi", bus.hi, 32'hCAFE_0001);
        check("mthi_lo", bus.lo, 32'h0000_1234);

        // reset during CALC step 10 aborts DIVU
        bus.start = 1'b1;
        bus.op    = 3'b011;
        bus.a     = 32'd1000;
        bus.b     = 32'd3;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        check("pre_rst_busy", {31'b0, bus.busy}, 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_busy", {31'b0, bus.busy}, 32'd0);
        check("abort_done", {31'b0, bus.done}, 32'd0);
        check("abort_hi", bus.hi, 32'd0);
        check("abort_lo", bus.lo, 32'd0);
        rst_n = 1'b1;
        run_op("multu_3x4", 3'b001, 32'd3, 32'd4, 32'd0, 32'h0000_000C);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
